// File: rtl/apb_master_ctrl.sv
// APB master: one command at a time through IDLE/SETUP/ACCESS/RESP, with
// optional ACCESS-phase timeout; every output is registered.
module apb_master_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_apbm,
    input  logic        rst_apbm_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_pstrb,
    input  logic [2:0]  cmd_pprot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        rsp_timeout,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_paddr,
    output logic [31:0] m_pwdata,
    output logic [2:0]  m_pprot,
    output logic [3:0]  m_pstrb,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] cnt;
    logic [16:0] cnt_next;
    logic        tmo_hit;

    assign cnt_next = {1'b0, cnt} + 17'd1;
    // pready has priority over a timeout expiring in the same cycle
    assign tmo_hit  = (TMO != 17'd0) && !m_pready && (cnt_next == TMO);

    always_ff @(posedge clk_apbm or negedge rst_apbm_n) begin
        if (!rst_apbm_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            m_pwrite    <= 1'b0;
            m_paddr     <= '0;
            m_pwdata    <= '0;
            m_pprot     <= '0;
            m_pstrb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        m_psel    <= 1'b1;
                        m_pwrite  <= cmd_write;
                        m_paddr   <= cmd_addr;
                        m_pwdata  <= cmd_wdata;
                        m_pprot   <= cmd_pprot;
                        m_pstrb   <= cmd_write ? cmd_pstrb : 4'h0;
                        cnt       <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    m_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (m_pready || tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= !m_pready;
                        rsp_slverr  <= m_pready ? m_pslverr : 1'b1;
                        rsp_rdata   <= (m_pready && !m_pwrite) ? m_prdata : 32'h0;
                        m_psel      <= 1'b0;
                        m_penable   <= 1'b0;
                        m_pwrite    <= 1'b0;
                        m_paddr     <= '0;
                        m_pwdata    <= '0;
                        m_pprot     <= '0;
                        m_pstrb     <= '0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt_next[15:0];
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b0;
                        rsp_timeout <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl (TIMEOUT_CYCLES=4); outputs sampled on negedge.
module tb_apb_master_ctrl;
    logic        clk_apbm = 1'b0;
    logic        rst_apbm_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_pstrb = '0;
    logic [2:0]  cmd_pprot = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] m_prdata = '0;
    logic        m_pready = 1'b0, m_pslverr = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata, m_paddr, m_pwdata;
    logic        m_psel, m_penable, m_pwrite;
    logic [2:0]  m_pprot;
    logic [3:0]  m_pstrb;

    int total = 0;
    int bad = 0;

    apb_master_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_apbm(clk_apbm), .rst_apbm_n(rst_apbm_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_pstrb(cmd_pstrb),
        .cmd_pprot(cmd_pprot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pprot(m_pprot),
        .m_pstrb(m_pstrb), .m_prdata(m_prdata), .m_pready(m_pready),
        .m_pslverr(m_pslverr)
    );

    always #5 clk_apbm = ~clk_apbm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_apbm);
    endtask

    // Presents a command while IDLE; returns at the negedge of the SETUP cycle.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        cmd_pstrb = s; cmd_pprot = p;
        cyc();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEAD_0000;
        chk("setup_psel_pen", {30'b0, m_psel, m_penable}, 32'b10);
        chk("setup_ready_low", {31'b0, cmd_ready}, 32'd0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_hs_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        // reset state
        cyc();
        chk("rst_outputs", {24'b0, cmd_ready, rsp_valid, rsp_slverr, rsp_timeout,
                            m_psel, m_penable, m_pwrite, 1'b0}, 32'd0);
        chk("rst_paddr", m_paddr, 32'd0);
        rst_apbm_n = 1'b1;
        cyc();

        // zero-wait write
        issue(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 3'b010);
        chk("wr_setup_addr", m_paddr, 32'h0000_0010);
        chk("wr_setup_wdata", m_pwdata, 32'hA5A5_5A5A);
        chk("wr_setup_ctl", {25'b0, m_pwrite, m_pstrb, m_pprot[1:0]}, {25'b0, 1'b1, 4'hF, 2'b10});
        m_pready = 1'b1; m_prdata = 32'hFFFF_FFFF;
        cyc();
        chk("wr_access", {30'b0, m_psel, m_penable}, 32'b11);
        chk("wr_access_noresp", {31'b0, rsp_valid}, 32'd0);
        cyc();
        m_pready = 1'b0;
        chk("wr_resp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("wr_resp_flags", {30'b0, rsp_slverr, rsp_timeout}, 32'd0);
        chk("wr_resp_rdata", rsp_rdata, 32'd0);
        chk("wr_resp_bus_idle", {30'b0, m_psel, m_penable}, 32'd0);
        chk("wr_resp_paddr", m_paddr, 32'd0);
        handshake();

        // read with 3 wait states and slave error, then a stalled response
        issue(1'b0, 32'h0000_0020, 32'h1111_1111, 4'hF, 3'b001);
        chk("rd_pstrb_zero", {28'b0, m_pstrb}, 32'd0);
        m_pready = 1'b0; m_pslverr = 1'b1; m_prdata = 32'hBBBB_BBBB;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rd_wait_pen", {30'b0, m_psel, m_penable}, 32'b11);
            chk("rd_wait_addr", m_paddr, 32'h0000_0020);
        end
        cyc();
        chk("rd_last_addr", m_paddr, 32'h0000_0020);
        m_pready = 1'b1; m_prdata = 32'h1234_5678;
        cyc();
        m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 32'h0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0040;
        cmd_wdata = 32'h5555_AAAA; cmd_pstrb = 4'h3; cmd_pprot = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk("rd_resp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rd_resp_rdata", rsp_rdata, 32'h1234_5678);
            chk("rd_resp_flags", {30'b0, rsp_slverr, rsp_timeout}, 32'b10);
            chk("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("stall_idle_psel", {31'b0, m_psel}, 32'd0);
        chk("stall_idle_ready", {31'b0, cmd_ready}, 32'd1);
        // pending cmd_valid is accepted at this IDLE cycle's edge: timeout write
        cyc();
        cmd_valid = 1'b0;
        chk("to_setup", {30'b0, m_psel, m_penable}, 32'b10);
        chk("to_setup_addr", m_paddr, 32'h0000_0040);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("to_access", {30'b0, m_psel, m_penable}, 32'b11);
            chk("to_access_noresp", {31'b0, rsp_valid}, 32'd0);
        end
        cyc();
        chk("to_resp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("to_resp_flags", {30'b0, rsp_slverr, rsp_timeout}, 32'b11);
        chk("to_resp_rdata", rsp_rdata, 32'd0);
        chk("to_bus_idle", {30'b0, m_psel, m_penable}, 32'd0);
        handshake();

        // pready on the 4th ACCESS cycle beats the timeout
        issue(1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'b100);
        m_pready = 1'b0; m_prdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) cyc();
        cyc();
        chk("race_access", {30'b0, m_psel, m_penable}, 32'b11);
        m_pready = 1'b1;
        cyc();
        m_pready = 1'b0;
        chk("race_resp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("race_resp_flags", {30'b0, rsp_slverr, rsp_timeout}, 32'd0);
        chk("race_resp_rdata", rsp_rdata, 32'hCAFE_F00D);
        handshake();

        // reset in ACCESS aborts the transfer
        issue(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b000);
        cyc();
        chk("abort_pre_access", {30'b0, m_psel, m_penable}, 32'b11);
        #1 rst_apbm_n = 1'b0;
        #1;
        chk("abort_bus", {29'b0, m_psel, m_penable, rsp_valid}, 32'd0);
        chk("abort_ready", {31'b0, cmd_ready}, 32'd0);
        cyc();
        cyc();
        rst_apbm_n = 1'b1;
        cyc();
        chk("abort_no_resp", {31'b0, rsp_valid}, 32'd0);
        issue(1'b0, 32'h0000_0080, 32'h0, 4'h0, 3'b000);
        chk("post_rst_addr", m_paddr, 32'h0000_0080);
        m_pready = 1'b1; m_prdata = 32'h0BAD_BEEF;
        cyc();
        cyc();
        m_pready = 1'b0;
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'd1);
        chk("post_rst_rdata", rsp_rdata, 32'h0BAD_BEEF);
        chk("post_rst_flags", {30'b0, rsp_slverr, rsp_timeout}, 32'd0);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
